bit_serial_adder: RTL and testbench

- Sequential adder, the arithmetic inverse of the ripple-carry subtractor: computes A + B + Cin one bit per clock, LSB first, through a single registered full-adder cell.
- Start/busy/done handshake; result and flags held stable until the next completion.
- Area-cheap alternative to the combinational ripple blocks; its results are cross-checked against the subtractor (Sum − B − Cin = A when Cout = 0).

---
 rtl/bit_serial_adder_pkg.sv | 15 +
 rtl/bit_serial_adder_full_adder.sv | 16 +
 rtl/bit_serial_adder.sv | 108 ++++++++++
 tb/tb_bit_serial_adder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared constants for the bit-serial adder: default width and FSM state encodings.
package bsa_pkg;

  localparam int unsigned BSA_DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The unused encoding 2'd3 is treated as IDLE so a corrupted state recovers.
  function automatic logic [1:0] bsa_decode_state(input logic [1:0] st);
    return ((st == ST_RUN) || (st == ST_DONE)) ? st : ST_IDLE;
  endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// Combinational 1-bit full adder used as the single arithmetic cell of the serial datapath.
module bsa_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_p;

  assign w_p    = i_a ^ i_b;
  assign o_s    = w_p ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/bit_serial_adder.sv
// Sequential A + B + Cin, one bit per clock LSB first, with start/busy/done handshake.
module bit_serial_adder
  import bsa_pkg::*;
#(
  parameter int unsigned WIDTH = BSA_DEFAULT_WIDTH
) (
  input  logic             bsa_clk,
  input  logic             bsa_rst_n,
  input  logic             bsa_start,
  input  logic [WIDTH-1:0] bsa_A,
  input  logic [WIDTH-1:0] bsa_B,
  input  logic             bsa_Cin,
  output logic             bsa_busy,
  output logic             bsa_done,
  output logic [WIDTH-1:0] bsa_Sum,
  output logic             bsa_Cout,
  output logic             bsa_Ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-2:0] r_sh_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_a;
  logic             r_sign_b;

  logic             w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_sum_next;

  assign w_state = bsa_decode_state(r_state);

  bsa_full_adder u_fa (
    .i_a    (r_sh_a[0]),
    .i_b    (r_sh_b[0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  // The partial sum keeps only WIDTH-1 bits; the final bit arrives straight from the adder.
  assign w_sum_next = {w_s, r_sh_sum};

  always_ff @(posedge bsa_clk) begin
    if (!bsa_rst_n) begin
      r_state  <= ST_IDLE;
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_sh_sum <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      bsa_busy <= 1'b0;
      bsa_done <= 1'b0;
      bsa_Sum  <= '0;
      bsa_Cout <= 1'b0;
      bsa_Ovf  <= 1'b0;
    end else begin
      bsa_done <= 1'b0;
      case (w_state)
        ST_IDLE: begin
          if (bsa_start) begin
            r_sh_a   <= bsa_A;
            r_sh_b   <= bsa_B;
            r_sh_sum <= '0;
            r_carry  <= bsa_Cin;
            r_cnt    <= '0;
            r_sign_a <= bsa_A[WIDTH-1];
            r_sign_b <= bsa_B[WIDTH-1];
            bsa_busy <= 1'b1;
            r_state  <= ST_RUN;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_sh_a   <= {1'b0, r_sh_a[WIDTH-1:1]};
          r_sh_b   <= {1'b0, r_sh_b[WIDTH-1:1]};
          r_sh_sum <= w_sum_next[WIDTH-1:1];
          r_carry  <= w_cout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            bsa_Sum  <= w_sum_next;
            bsa_Cout <= w_cout;
            bsa_Ovf  <= (r_sign_a == r_sign_b) && (w_s != r_sign_a);
            bsa_busy <= 1'b0;
            bsa_done <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Randomized, self-checking bench for bit_serial_adder against an arithmetic reference model.
module tb_bit_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .bsa_clk   (clk),
    .bsa_rst_n (rst_n),
    .bsa_start (start),
    .bsa_A     (a),
    .bsa_B     (b),
    .bsa_Cin   (cin),
    .bsa_busy  (busy),
    .bsa_done  (done),
    .bsa_Sum   (sum),
    .bsa_Cout  (cout),
    .bsa_Ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: a countdown of cycles left in the operation plus the arithmetic result.
  int             m_timer = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_sum = '0;
  logic             m_cin = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
  logic [WIDTH:0]   m_full;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_timer = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else if (m_timer == 0) begin
      if (start) begin
        m_a = a; m_b = b; m_cin = cin;
        m_timer = WIDTH + 1;
      end
    end else begin
      m_timer = m_timer - 1;
      if (m_timer == 1) begin
        m_full = {1'b0, m_a} + {1'b0, m_b} + {{WIDTH{1'b0}}, m_cin};
        m_sum  = m_full[WIDTH-1:0];
        m_cout = m_full[WIDTH];
        m_ovf  = (m_a[WIDTH-1] == m_b[WIDTH-1]) && (m_sum[WIDTH-1] != m_a[WIDTH-1]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_timer > 1));
      check("done", 32'(done), 32'(m_timer == 1));
      check("sum",  32'(sum),  32'(m_sum));
      check("cout", 32'(cout), 32'(m_cout));
      check("ovf",  32'(ovf),  32'(m_ovf));
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 4 * WIDTH; k++) begin
      if (m_timer == 0) return;
      step();
    end
    check("idle_wait", 32'(m_timer), 32'd0);
  endtask

  // Issue one accepted start, scramble operands afterwards, and wait for done.
  task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                        input logic oc, output int lat);
    wait_idle();
    a = oa; b = ob; cin = oc; start = 1'b1;
    step();
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    lat = 0;
    for (int k = 0; k < 3 * WIDTH; k++) begin
      if (done === 1'b1) break;
      step();
      lat++;
    end
  endtask

  task automatic lit(input string name, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    check({name, "_sum"},  32'(sum),  32'(es));
    check({name, "_cout"}, 32'(cout), 32'(ec));
    check({name, "_ovf"},  32'(ovf),  32'(eo));
  endtask

  initial begin
    int lat;
    int d0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    step();
    lit("reset", 8'h00, 1'b0, 1'b0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();

    run_op(8'h02, 8'h01, 1'b1, lat);
    check("t1_latency", 32'(lat), 32'(WIDTH));
    lit("t1", 8'h04, 1'b0, 1'b0);

    wait_idle();
    a = 8'h07; b = 8'h04; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("t2_busy_after_accept", 32'(busy), 32'd1);
    check("t2_hold_prev", 32'(sum), 32'h04);
    for (int k = 0; k < WIDTH - 1; k++) step();
    check("t2_hold_late", 32'(sum), 32'h04);
    step();
    check("t2_done", 32'(done), 32'd1);
    lit("t2", 8'h0C, 1'b0, 1'b0);

    run_op(8'hFF, 8'h01, 1'b0, lat);
    lit("t3", 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, lat);
    lit("t4", 8'h80, 1'b0, 1'b1);
    run_op(8'h80, 8'h80, 1'b0, lat);
    lit("t5", 8'h00, 1'b1, 1'b1);

    // Start while RUN must be ignored.
    wait_idle();
    d0 = done_cnt;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle();
    step(); step();
    lit("t6", 8'h30, 1'b0, 1'b0);
    check("t6_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Reset mid-RUN aborts the operation.
    wait_idle();
    a = 8'h33; b = 8'h44; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    d0 = done_cnt;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    lit("t7_rst", 8'h00, 1'b0, 1'b0);
    check("t7_busy", 32'(busy), 32'd0);
    for (int k = 0; k < WIDTH + 3; k++) step();
    check("t7_no_done", 32'(done_cnt - d0), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, lat);
    lit("t7_after", 8'h02, 1'b0, 1'b0);

    // Free-running random traffic with start spam and rare resets.
    for (int k = 0; k < 800; k++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      cin = 1'($urandom);
      start = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 2 * WIDTH; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
